// File: rtl/test_i7156.sv
// Five-bit registered logic term whose result inverts once the input register has shown
// TRIG_A and then TRIG_B on consecutive cycles; the inversion holds until reset.
module test_i7156 #(
  parameter logic [4:0] TRIG_A = 5'b10101,
  parameter logic [4:0] TRIG_B = 5'b01010
) (
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N4,
  input  logic CK,
  input  logic reset,
  output logic Y
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEN_A = 2'd1,
    ARMED  = 2'd2
  } state_t;

  // r_q[0] holds N0 so the register lines up with patterns written {N0,...,N4}.
  logic [0:4] r_q;
  state_t     state_q;
  state_t     state_d;
  logic       yc;
  logic       y_q;
  logic       y_d;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_q <= 5'b00000;
    end else begin
      r_q <= {N0, N1, N2, N3, N4};
    end
  end

  assign yc = ((r_q[0] & r_q[1]) | (r_q[2] & ~r_q[3])) ^ r_q[4];

  // The TRIG_B test comes first in SEEN_A so equal triggers still arm.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (r_q == TRIG_A) state_d = SEEN_A;
      end
      SEEN_A: begin
        if (r_q == TRIG_B)      state_d = ARMED;
        else if (r_q == TRIG_A) state_d = SEEN_A;
        else                    state_d = IDLE;
      end
      ARMED:   state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  assign y_d = yc ^ (state_q == ARMED);

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_test_i7156.sv
// Scoreboard bench for test_i7156: the driver queues the expected Y for each pattern it
// applies, and a monitor on the falling edge compares each entry two rising edges later.
module tb_test_i7156;

  logic N0, N1, N2, N3, N4;
  logic CK;
  logic reset;
  logic Y;
  logic Y2;

  int n_tests;
  int n_fail;
  int cyc;

  typedef struct {
    logic  sel;
    logic  exp;
    int    due;
    string name;
  } sb_entry_t;

  sb_entry_t exp_q[$];

  test_i7156 dut (
    .N0(N0), .N1(N1), .N2(N2), .N3(N3), .N4(N4),
    .CK(CK), .reset(reset), .Y(Y)
  );

  // Equal triggers exercise the arm-over-stay priority in SEEN_A.
  test_i7156 #(.TRIG_A(5'b11100), .TRIG_B(5'b11100)) dut_eq (
    .N0(N0), .N1(N1), .N2(N2), .N3(N3), .N4(N4),
    .CK(CK), .reset(reset), .Y(Y2)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: Y=%0b expected %0b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops every entry whose output is now due.
  always @(negedge CK) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      if (exp_q[0].sel) chk(exp_q[0].name, Y2, exp_q[0].exp);
      else              chk(exp_q[0].name, Y, exp_q[0].exp);
      void'(exp_q.pop_front());
    end
  end

  // Pattern is written {N0,N1,N2,N3,N4}; called just after a falling edge.
  task automatic apply(input logic [4:0] p, input logic e, input logic sel, input string nm);
    sb_entry_t ent;
    {N0, N1, N2, N3, N4} = p;
    ent.sel  = sel;
    ent.exp  = e;
    ent.due  = cyc + 2;
    ent.name = nm;
    exp_q.push_back(ent);
    @(negedge CK);
  endtask

  task automatic flush();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(negedge CK);
      k++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL flush: %0d entries pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Reset asserted between edges, checked immediately, released on the next falling edge.
  task automatic do_reset(input string nm);
    flush();
    #2 reset = 1'b0;
    #1 chk(nm, Y, 1'b0);
    @(negedge CK);
    reset = 1'b1;
  endtask

  function automatic logic yc_of(input logic [4:0] p);
    logic n0, n1, n2, n3, n4;
    {n0, n1, n2, n3, n4} = p;
    return ((n0 & n1) | (n2 & ~n3)) ^ n4;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] p;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    reset   = 1'b0;
    {N0, N1, N2, N3, N4} = 5'b11111;
    repeat (2) @(negedge CK);
    chk("reset_state", Y, 1'b0);
    chk("reset_state_eq", Y2, 1'b0);
    reset = 1'b1;

    // Hand-computed core term values.
    apply(5'b00000, 1'b0, 1'b0, "hand_00000");
    apply(5'b00001, 1'b1, 1'b0, "hand_00001");
    apply(5'b11000, 1'b1, 1'b0, "hand_11000");
    apply(5'b00101, 1'b0, 1'b0, "hand_00101");

    do_reset("rst_sweep");
    for (int i = 0; i < 32; i++) begin
      p = i[4:0];
      apply(p, yc_of(p), 1'b0, "sweep");
    end

    do_reset("rst_arm");
    apply(5'b10101, 1'b0, 1'b0, "arm_a");
    apply(5'b01010, 1'b0, 1'b0, "arm_b");
    apply(5'b00000, 1'b1, 1'b0, "arm_hold0");
    apply(5'b00000, 1'b1, 1'b0, "arm_hold1");
    apply(5'b00000, 1'b1, 1'b0, "arm_hold2");

    do_reset("rst_gap");
    apply(5'b10101, 1'b0, 1'b0, "gap_a");
    apply(5'b00000, 1'b0, 1'b0, "gap_0");
    apply(5'b01010, 1'b0, 1'b0, "gap_b");
    apply(5'b00000, 1'b0, 1'b0, "gap_after");
    apply(5'b11000, 1'b1, 1'b0, "gap_11000");

    do_reset("rst_aab");
    apply(5'b10101, 1'b0, 1'b0, "aab_a1");
    apply(5'b10101, 1'b0, 1'b0, "aab_a2");
    apply(5'b01010, 1'b0, 1'b0, "aab_b");
    apply(5'b11000, 1'b0, 1'b0, "aab_11000_inv");
    apply(5'b00001, 1'b0, 1'b0, "aab_00001_inv");
    flush();

    // Reset while armed: Y must drop at once, and inversion must be gone afterwards.
    #2 reset = 1'b0;
    #1 chk("armed_reset_immediate", Y, 1'b0);
    @(negedge CK);
    reset = 1'b1;
    apply(5'b00001, 1'b1, 1'b0, "post_reset_00001");
    apply(5'b00000, 1'b0, 1'b0, "post_reset_00000");
    flush();

    // Reset held while the arming sequence is driven.
    reset = 1'b0;
    {N0, N1, N2, N3, N4} = 5'b10101;
    @(negedge CK);
    chk("held_reset_a", Y, 1'b0);
    {N0, N1, N2, N3, N4} = 5'b01010;
    @(negedge CK);
    chk("held_reset_b", Y, 1'b0);
    {N0, N1, N2, N3, N4} = 5'b11000;
    @(negedge CK);
    chk("held_reset_c", Y, 1'b0);
    reset = 1'b1;
    apply(5'b00000, 1'b0, 1'b0, "held_after_00000");
    apply(5'b11000, 1'b1, 1'b0, "held_after_11000");

    // Equal triggers: 11100 twice arms on the second SEEN_A check.
    do_reset("rst_eq");
    apply(5'b11100, 1'b1, 1'b1, "eq_first");
    apply(5'b11100, 1'b1, 1'b1, "eq_second");
    apply(5'b00000, 1'b1, 1'b1, "eq_armed0");
    apply(5'b00000, 1'b1, 1'b1, "eq_armed1");
    flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
